// File: rtl/lsu_wb_subword.sv
// Data-side load/store unit acting as a Wishbone classic master for byte/half/word accesses.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses into two locked bus beats.
module lsu_wb_subword #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TAGSIZE        = 1,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic                  wb_lock_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  output logic [TAGSIZE-1:0]    wb_tga_o,
  output logic [TAGSIZE-1:0]    wb_tgd_o,
  output logic [TAGSIZE-1:0]    wb_tgc_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i
);
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q, uns_q, bad_q;
  logic [31:0]           data_q;
  logic [RW-1:0]         rty_q, rty_d;
  logic [TW-1:0]         to_q, to_d;

  logic                  cyc_q, cyc_d, stb_q, stb_d, lock_q, lock_d, wbwe_q, wbwe_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d, rdata_q, rdata_d;
  logic                  valid_q, valid_d, err_q, err_d;

  logic [ADDR_WIDTH-1:0] cur_addr, base;
  logic [1:0]            cur_size, cur_off;
  logic [31:0]           cur_data, dat1, ld_sh, ld_val;
  logic [4:0]            sh;
  logic [3:0]            mask, sel1;
  logic                  mis, bad_in, fail, done;
`ifdef LSU_MISALIGN_EN
  logic                  split_q;
  logic [31:0]           beat1_q, beat1_d, dat2;
  logic [7:0]            lanes;
  logic [63:0]           st64;
  logic [3:0]            sel2;
`endif

  // Live inputs while idle so the bus outputs can be registered in the accept cycle.
  always_comb begin
    cur_addr = (state_q == IDLE) ? addr_i : addr_q;
    cur_size = (state_q == IDLE) ? size_i : size_q;
    cur_data = (state_q == IDLE) ? data_i : data_q;
    cur_off  = cur_addr[1:0];
    sh       = {cur_off, 3'b000};
    base     = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
    case (cur_size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    mis = ((cur_size == 2'b01) && (cur_off == 2'b11)) ||
          ((cur_size == 2'b10) && (cur_off != 2'b00));
`ifdef LSU_MISALIGN_EN
    bad_in = (cur_size == 2'b11);
    lanes  = {4'b0000, mask} << cur_off;
    sel1   = lanes[3:0];
    sel2   = lanes[7:4];
    st64   = {32'h0, cur_data} << sh;
    dat1   = st64[31:0];
    dat2   = st64[63:32];
    ld_sh  = 32'(((state_q == BEAT2) ? {wb_dat_i, beat1_q} : {32'h0, wb_dat_i}) >> sh);
`else
    bad_in = (cur_size == 2'b11) || mis;
    sel1   = mask << cur_off;
    dat1   = cur_data << sh;
    ld_sh  = wb_dat_i >> sh;
`endif
    case (size_q)
      2'b00:   ld_val = {{24{~uns_q & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_val = {{16{~uns_q & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    lock_d  = lock_q;
    wbwe_d  = wbwe_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    rty_d   = rty_q;
    to_d    = to_q;
    fail    = 1'b0;
    done    = 1'b0;
`ifdef LSU_MISALIGN_EN
    beat1_d = beat1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          // Rejected requests still pass through BEAT1 (bus idle) so the error
          // response lands with the same latency as a zero-wait access.
          state_d = BEAT1;
          rty_d   = '0;
          to_d    = '0;
          if (!bad_in) begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            wbwe_d = we_i;
            adr_d  = base;
            sel_d  = sel1;
            dat_d  = dat1;
`ifdef LSU_MISALIGN_EN
            lock_d = mis;
`endif
          end
        end
      end
      BEAT1, BEAT2: begin
        if (bad_q) begin
          fail = 1'b1;
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end else if (wb_err_i) begin
          fail = 1'b1;
        end else if (wb_rty_i) begin
          if (rty_q == RW'(MAX_RETRY)) begin
            fail = 1'b1;
          end else begin
            rty_d = rty_q + RW'(1);
            to_d  = '0;
            stb_d = 1'b0;
          end
        end else if (wb_ack_i) begin
`ifdef LSU_MISALIGN_EN
          if ((state_q == BEAT1) && split_q) begin
            state_d = BEAT2;
            adr_d   = base + ADDR_WIDTH'(4);
            sel_d   = sel2;
            dat_d   = dat2;
            rty_d   = '0;
            to_d    = '0;
            beat1_d = wb_dat_i;
          end else begin
            done = 1'b1;
          end
`else
          done = 1'b1;
`endif
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fail || done) begin
      state_d = RESP;
      valid_d = 1'b1;
      err_d   = fail;
      rdata_d = (done && !we_q) ? ld_val : '0;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      lock_d  = 1'b0;
      wbwe_d  = 1'b0;
      adr_d   = '0;
      sel_d   = '0;
      dat_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      rty_q   <= '0;
      to_q    <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      lock_q  <= 1'b0;
      wbwe_q  <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
      split_q <= 1'b0;
      beat1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rty_q   <= rty_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      lock_q  <= lock_d;
      wbwe_q  <= wbwe_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_EN
      beat1_q <= beat1_d;
`endif
      if ((state_q == IDLE) && req_i) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        data_q  <= data_i;
        bad_q   <= bad_in;
`ifdef LSU_MISALIGN_EN
        split_q <= mis;
`endif
      end
    end
  end

  assign data_o    = rdata_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != IDLE);
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = wbwe_q;
  assign wb_lock_o = lock_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign wb_tga_o  = '0;
  assign wb_tgd_o  = '0;
  assign wb_tgc_o  = '0;
endmodule
